argmax_layer: RTL and testbench
===============================

# argmax_layer

Final classification stage of the MNIST inference pipeline. It receives the `IN_SIZE` signed class scores from the last dense layer as a serial stream. It tracks the running maximum and reports the index of the largest score once all scores have arrived. The result drives the digit display/readout logic.

## Interface
- `IN_SIZE`, 10: number of class scores per inference.
- `DATA_WIDTH`, 16: width of each signed score.
- `INDEX_WIDTH`, 4: width of `index_out`; must satisfy 2^INDEX_WIDTH >= IN_SIZE.

Ports:
- `clk`, input, 1: rising-edge clock; the only clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start_argmax`, input, 1: one-cycle pulse that begins a new inference.
- `data_valid`, input, 1: `class_in` holds a valid score this cycle.
- `class_in`, input, DATA_WIDTH: signed (two's complement) class score.
- `finish_argmax`, output, 1: one-cycle done pulse.
- `index_out`, output, INDEX_WIDTH: index (0-based, arrival order) of the maximum score.

## Operation
- FSM states:
  - IDLE: waits for `start_argmax`.
  - ACCUM: consumes scores.
  - DONE: one cycle; asserts `finish_argmax`, then returns to IDLE.
- IDLE → ACCUM on `start_argmax`. On that edge:
  - sample counter cleared to 0;
  - running max and running index cleared.
- In ACCUM, each edge with `data_valid=1` accepts one score:
  - Sample 0 loads max = `class_in` and index = 0 unconditionally, so all-negative inputs work.
  - Later samples update max/index only when `class_in` > max, using a signed compare. Ties keep the earliest index.
  - The counter increments on every accepted sample.
- Accepting sample `IN_SIZE-1` moves ACCUM → DONE. On the same edge, the final index is written to `index_out`.
- Gaps are allowed: `data_valid=0` cycles in ACCUM are idle and do not advance the counter.
- `data_valid` is ignored in IDLE and DONE. Extra samples after the last one have no effect.
- `start_argmax` in ACCUM or DONE restarts: counter and running max are cleared and the FSM goes to ACCUM. `index_out` keeps its previous value until the new result completes.
- `start_argmax` has priority over `data_valid` in the same cycle. That cycle's sample is not accepted.
- `index_out` holds its value from one DONE until the next completed inference.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release):
  - state = IDLE;
  - counter = 0;
  - running max = 0;
  - `finish_argmax` = 0;
  - `index_out` = 0.
- Reset asserted mid-inference aborts it. No `finish_argmax` is produced.
- All outputs are registered.
- Latency: `finish_argmax` is high for exactly the one cycle following the edge that accepted the last score. `index_out` is valid from that cycle onward.
- Minimum inference time: 1 start cycle + IN_SIZE valid cycles + 1 DONE cycle.
- A new `start_argmax` is accepted in the DONE cycle itself (back-to-back operation).

## Configuration
- `ARGMAX_MAX_VALUE_EN`, when defined:
  - adds output `max_value` [DATA_WIDTH-1:0], signed, holding the maximum score;
  - `max_value` is registered, updated on the same edge as `index_out`, and reset to 0.
- When not defined: the port does not exist and the running-max register is internal only.

## Test plan
- Reset, start, then scores 5,17,3,99,42,0,12,98,7,1 with continuous valid → `finish_argmax` pulses once, one cycle after the 10th sample; `index_out`=3.
- All-negative scores -50,-3,-20,-3,-100,-7,-9,-8,-60,-4 → `index_out`=1 (tie with index 3 keeps the first); `max_value`=-3 when `ARGMAX_MAX_VALUE_EN` is defined.
- Scores ascending 0..9 with `data_valid` deasserted every other cycle → `index_out`=9; `finish_argmax` only after the 10th valid sample. `data_valid` held high for 2 extra cycles → no second pulse and `index_out` unchanged.
- Second `start_argmax` after 4 samples, then 10 fresh scores with max at position 6 → single `finish_argmax`; `index_out`=6.
- `reset_n` pulled low after 5 samples → outputs 0 immediately. After release, no `finish_argmax` until a full start + 10-sample sequence completes.
- Random scores in 0..100 (signed) over 1000 inferences → `index_out` matches a first-occurrence argmax reference model every time.

Source files
------------

// File: rtl/argmax_layer.sv
// argmax_layer: final classification stage. Consumes IN_SIZE signed class
// scores as a serial stream, tracks the running maximum and reports the
// 0-based arrival index of the largest score (earliest index wins ties).
//
// Optional feature macro: ARGMAX_MAX_VALUE_EN adds the max_value output.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   start_argmax  one-cycle pulse, begins (or restarts) an inference
//   data_valid    class_in carries a valid score this cycle
//   class_in      signed class score
//   finish_argmax one-cycle done pulse (registered)
//   index_out     index of the maximum score (registered, held until next result)
//   max_value     maximum score (registered, only with ARGMAX_MAX_VALUE_EN)
module argmax_layer #(
   parameter int unsigned IN_SIZE     = 10,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned INDEX_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start_argmax,
   input  logic                          data_valid,
   input  logic signed [DATA_WIDTH-1:0]  class_in,
`ifdef ARGMAX_MAX_VALUE_EN
   output logic signed [DATA_WIDTH-1:0]  max_value,
`endif
   output logic                          finish_argmax,
   output logic        [INDEX_WIDTH-1:0] index_out
);

   localparam int unsigned CNT_W = (IN_SIZE > 32'd1) ? 32'($clog2(IN_SIZE)) : 32'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic        [CNT_W-1:0]       cnt_q, cnt_d;
   logic signed [DATA_WIDTH-1:0]  max_q, max_d;
   logic        [INDEX_WIDTH-1:0] ridx_q, ridx_d;
   logic        [INDEX_WIDTH-1:0] index_d;
   logic                          finish_d;
   logic                          take_new;
   logic                          last_sample;
`ifdef ARGMAX_MAX_VALUE_EN
   logic signed [DATA_WIDTH-1:0]  max_value_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         max_q         <= '0;
         ridx_q        <= '0;
         finish_argmax <= 1'b0;
         index_out     <= '0;
`ifdef ARGMAX_MAX_VALUE_EN
         max_value     <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         max_q         <= max_d;
         ridx_q        <= ridx_d;
         finish_argmax <= finish_d;
         index_out     <= index_d;
`ifdef ARGMAX_MAX_VALUE_EN
         max_value     <= max_value_d;
`endif
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      ridx_d      = ridx_q;
      index_d     = index_out;
      finish_d    = 1'b0;
`ifdef ARGMAX_MAX_VALUE_EN
      max_value_d = max_value;
`endif
      // Sample 0 always loads so all-negative streams resolve correctly;
      // strict '>' keeps the earliest index on ties.
      take_new    = (cnt_q == '0) || (class_in > max_q);
      last_sample = (cnt_q == CNT_W'(IN_SIZE - 1));

      if (start_argmax) begin
         // Start wins over data_valid in any state; the same-cycle sample is dropped.
         state_d = ACCUM;
         cnt_d   = '0;
         max_d   = '0;
         ridx_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ACCUM: begin
               if (data_valid) begin
                  if (take_new) begin
                     max_d  = class_in;
                     ridx_d = INDEX_WIDTH'(cnt_q);
                  end
                  cnt_d = cnt_q + CNT_W'(1);
                  if (last_sample) begin
                     state_d     = DONE;
                     cnt_d       = '0;
                     finish_d    = 1'b1;
                     index_d     = ridx_d;
`ifdef ARGMAX_MAX_VALUE_EN
                     max_value_d = max_d;
`endif
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_argmax_layer.sv
// Self-checking bench for argmax_layer: directed cases followed by 1000
// randomized inferences compared against a first-occurrence argmax model.
module tb_argmax_layer;

   localparam int unsigned IN_SIZE     = 10;
   localparam int unsigned DATA_WIDTH  = 16;
   localparam int unsigned INDEX_WIDTH = 4;

   logic                          clk;
   logic                          reset_n;
   logic                          start_argmax;
   logic                          data_valid;
   logic signed [DATA_WIDTH-1:0]  class_in;
   logic                          finish_argmax;
   logic        [INDEX_WIDTH-1:0] index_out;
`ifdef ARGMAX_MAX_VALUE_EN
   logic signed [DATA_WIDTH-1:0]  max_value;
`endif

   int n_vec;
   int n_err;
   int fin_cnt;

   argmax_layer #(
      .IN_SIZE     (IN_SIZE),
      .DATA_WIDTH  (DATA_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_argmax  (start_argmax),
      .data_valid    (data_valid),
      .class_in      (class_in),
`ifdef ARGMAX_MAX_VALUE_EN
      .max_value     (max_value),
`endif
      .finish_argmax (finish_argmax),
      .index_out     (index_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (finish_argmax === 1'b1) fin_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: first index holding the largest score
   function automatic int ref_argmax(input int sc[$]);
      int best = 0;
      for (int i = 1; i < sc.size(); i++)
         if (sc[i] > sc[best]) best = i;
      return best;
   endfunction

   function automatic int ref_max(input int sc[$]);
      return sc[ref_argmax(sc)];
   endfunction

   // All tasks start and end 1 time unit after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse(input bit with_valid);
      start_argmax = 1'b1;
      data_valid   = with_valid;
      class_in     = 16'sd32767;
      tick();
      start_argmax = 1'b0;
      data_valid   = 1'b0;
   endtask

   // gap_mode: 0 continuous, 1 idle cycle between samples, 2 random idle cycles
   task automatic feed(input int sc[$], input int gap_mode);
      for (int i = 0; i < sc.size(); i++) begin
         if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
            data_valid = 1'b0;
            class_in   = DATA_WIDTH'($urandom);
            tick();
         end
         data_valid = 1'b1;
         class_in   = DATA_WIDTH'(sc[i]);
         tick();
      end
      data_valid = 1'b0;
   endtask

   // Called in the DONE cycle after the last sample was accepted
   task automatic check_result(input string tag, input int sc[$]);
      check({tag, "_finish"}, int'(finish_argmax), 1);
      check({tag, "_index"}, int'(index_out), ref_argmax(sc));
`ifdef ARGMAX_MAX_VALUE_EN
      check({tag, "_max"}, int'(max_value), ref_max(sc));
`endif
   endtask

   initial begin
      int sc[$];
      int part[$];
      int f0;
      bit b2b;

      n_vec = 0; n_err = 0; fin_cnt = 0;
      reset_n = 1'b0; start_argmax = 1'b0; data_valid = 1'b0; class_in = '0;
      tick(); tick();
      check("rst_finish", int'(finish_argmax), 0);
      check("rst_index", int'(index_out), 0);
`ifdef ARGMAX_MAX_VALUE_EN
      check("rst_max", int'(max_value), 0);
`endif
      reset_n = 1'b1;
      tick();

      // Basic positive scores
      sc = '{5, 17, 3, 99, 42, 0, 12, 98, 7, 1};
      f0 = fin_cnt;
      start_pulse(1'b0);
      feed(sc, 0);
      check_result("basic", sc);
      tick();
      check("basic_fin_low", int'(finish_argmax), 0);
      check("basic_pulses", fin_cnt - f0, 1);

      // All negative with a tie
      sc = '{-50, -3, -20, -3, -100, -7, -9, -8, -60, -4};
      start_pulse(1'b0);
      feed(sc, 0);
      check_result("neg", sc);
      check("neg_index_const", int'(index_out), 1);
      tick();

      // Ascending with gaps, then extra valid samples
      sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      f0 = fin_cnt;
      start_pulse(1'b0);
      feed(sc, 1);
      check_result("asc", sc);
      data_valid = 1'b1; class_in = 16'sd1000;
      tick(); tick();
      data_valid = 1'b0;
      check("asc_extra_fin", int'(finish_argmax), 0);
      check("asc_pulses", fin_cnt - f0, 1);
      check("asc_index_hold", int'(index_out), 9);

      // Restart after 4 samples; max of the fresh stream at position 6
      part = '{30000, 30001, 30002, 30003};
      sc   = '{1, 2, 3, 4, 5, 6, 77, 7, 8, 9};
      f0   = fin_cnt;
      start_pulse(1'b0);
      feed(part, 0);
      check("restart_index_held", int'(index_out), 9);
      start_pulse(1'b1);
      feed(sc, 0);
      check_result("restart", sc);
      tick();
      check("restart_pulses", fin_cnt - f0, 1);

      // Reset mid-inference
      sc = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      start_pulse(1'b0);
      part = '{1, 2, 100, 4, 5};
      feed(part, 0);
      reset_n = 1'b0;
      #1;
      check("midrst_index", int'(index_out), 0);
      check("midrst_finish", int'(finish_argmax), 0);
      tick();
      reset_n = 1'b1;
      f0 = fin_cnt;
      feed(sc, 0);
      tick();
      check("midrst_no_pulse", fin_cnt - f0, 0);
      start_pulse(1'b0);
      feed(sc, 0);
      check_result("midrst_full", sc);
      tick();
      check("midrst_pulses", fin_cnt - f0, 1);

      // Randomized inferences, occasional back-to-back and start/valid collisions
      b2b = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         sc.delete();
         for (int i = 0; i < int'(IN_SIZE); i++) sc.push_back(int'($urandom_range(0, 100)));
         if (!b2b) start_pulse(1'($urandom_range(0, 1)));
         f0 = fin_cnt;
         feed(sc, ($urandom_range(0, 1) == 1) ? 2 : 0);
         check_result("rand", sc);
         b2b = 1'($urandom_range(0, 1));
         if (b2b) start_pulse(1'($urandom_range(0, 1)));
         else tick();
         check("rand_fin_low", int'(finish_argmax), 0);
         check("rand_pulses", fin_cnt - f0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
